dmem_arbiter: RTL and testbench

- Shares the single data-memory SRAM port between two requesters: the CPU MEM stage and the external load/debug port.
- CPU has default priority. The external requester gets a starvation guarantee after STARVE_LIMIT lost cycles.
- When the CPU loses arbitration, the block raises a stall that the pipeline uses to gate its enable.
- One-cycle SRAM read data is routed back to whichever requester issued the read.

---
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data SRAM port between CPU MEM stage and external port, CPU priority with starvation guard
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {NORMAL, EXT_FORCE} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  state_t state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic rd_pend, rd_owner, cpu_win, ext_win;
  // all grants are masked while reset is held so the SRAM sees no access
  always_comb begin
    ext_win = arst_n & ext_req & (~cpu_req | state == EXT_FORCE);
    cpu_win = arst_n & cpu_req & ~ext_win;
    starve_nxt = (ext_req & ~ext_win) ? ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= NORMAL;
      starve_cnt <= '0;
      rd_pend <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state <= state_nxt;
      starve_cnt <= starve_nxt;
      rd_pend <= mem_en & ~mem_wen;
      if (mem_en & ~mem_wen) rd_owner <= ext_win;
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == NORMAL) state_nxt = (starve_nxt == LIMIT) ? EXT_FORCE : NORMAL;
    else state_nxt = (ext_win | ~ext_req) ? NORMAL : EXT_FORCE;
  end
  always_comb begin
    mem_en = cpu_win | ext_win;
    mem_wen = ext_win ? ext_wen : cpu_win & cpu_wen;
    mem_addr = ext_win ? ext_addr : cpu_win ? cpu_addr : '0;
    mem_wdata = ext_win ? ext_wdata : cpu_win ? cpu_wdata : '0;
    cpu_stall = arst_n & cpu_req & ~cpu_win;
    ext_gnt = ext_win;
    cpu_rvalid = arst_n & rd_pend & ~rd_owner;
    ext_rvalid = arst_n & rd_pend & rd_owner;
    cpu_rdata = cpu_rvalid ? mem_rdata : '0;
    ext_rdata = ext_rvalid ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed check of dmem_arbiter plus a reset-mid-read sequence
module tb_dmem_arbiter;
  logic clk = 0, arst_n;
  logic cpu_req, cpu_wen, ext_req, ext_wen;
  logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_wen;
  logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic rst_n, cr, cw;
    logic [63:0] ca, cd;
    logic er, ew;
    logic [63:0] ea, ed, rd;
  } in_t;
  typedef struct packed {
    logic en, wen;
    logic [63:0] addr, wdata;
    logic stall, crv;
    logic [63:0] crd;
    logic gnt, erv;
    logic [63:0] erd;
  } out_t;
  typedef struct packed {in_t i; out_t o;} vec_t;
  vec_t tbl[$];
  out_t act;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .arst_n(arst_n),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign act = {mem_en, mem_wen, mem_addr, mem_wdata, cpu_stall, cpu_rvalid, cpu_rdata, ext_gnt, ext_rvalid, ext_rdata};

  function automatic in_t mi(logic r, logic cr, logic cw, logic [63:0] ca, logic [63:0] cd,
                             logic er, logic ew, logic [63:0] ea, logic [63:0] ed, logic [63:0] rd);
    return {r, cr, cw, ca, cd, er, ew, ea, ed, rd};
  endfunction

  function automatic out_t mo(logic en, logic wen, logic [63:0] addr, logic [63:0] wdata, logic stall,
                              logic crv, logic [63:0] crd, logic gnt, logic erv, logic [63:0] erd);
    return {en, wen, addr, wdata, stall, crv, crd, gnt, erv, erd};
  endfunction

  task automatic apply(input in_t i);
    {arst_n, cpu_req, cpu_wen, cpu_addr, cpu_wdata, ext_req, ext_wen, ext_addr, ext_wdata, mem_rdata} = i;
  endtask

  task automatic check(input string nm, input out_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic step(input string nm, input in_t i, input out_t e);
    apply(i);
    @(negedge clk);
    check(nm, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t z;
    z = '0;
    for (int k = 0; k < 3; k++)
      tbl.push_back({mi(0, 1, 0, 'h10, 0, 1, 0, 'h40, 0, 'hAA), z});
    // lone CPU read and its return
    tbl.push_back({mi(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0), mo(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF), mo(0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0)});
    // starvation: four CPU wins, then a forced EXT grant
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 0), mo(1, 0, 'h30, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h11), mo(1, 0, 'h30, 0, 0, 1, 'h11, 0, 0, 0)});
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h22), mo(1, 0, 'h30, 0, 0, 1, 'h22, 0, 0, 0)});
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h33), mo(1, 0, 'h30, 0, 0, 1, 'h33, 0, 0, 0)});
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h44), mo(1, 0, 'h40, 0, 1, 1, 'h44, 1, 0, 0)});
    tbl.push_back({mi(1, 1, 0, 'h30, 0, 1, 0, 'h48, 0, 'h55), mo(1, 0, 'h30, 0, 0, 0, 0, 0, 1, 'h55)});
    // alternating owners
    tbl.push_back({mi(1, 1, 0, 'h08, 0, 0, 0, 0, 0, 'h66), mo(1, 0, 'h08, 0, 0, 1, 'h66, 0, 0, 0)});
    tbl.push_back({mi(1, 0, 0, 0, 0, 1, 0, 'h18, 0, 'h77), mo(1, 0, 'h18, 0, 0, 1, 'h77, 1, 0, 0)});
    tbl.push_back({mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h88), mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h88)});
    // writes from both sides return nothing
    tbl.push_back({mi(1, 0, 0, 0, 0, 1, 1, 'h20, 'h1234, 'h99), mo(1, 1, 'h20, 'h1234, 0, 0, 0, 1, 0, 0)});
    tbl.push_back({mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 'hAA), z});
    tbl.push_back({mi(1, 1, 1, 'h28, 'h5678, 0, 0, 0, 0, 0), mo(1, 1, 'h28, 'h5678, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 'hBB), z});

    #1;
    for (int k = 0; k < tbl.size(); k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

    // reset mid-read with starve_cnt preloaded to 3
    step("pre0", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 0), mo(1, 0, 'h30, 0, 0, 0, 0, 0, 0, 0));
    step("pre1", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h12), mo(1, 0, 'h30, 0, 0, 1, 'h12, 0, 0, 0));
    step("pre2", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h13), mo(1, 0, 'h30, 0, 0, 1, 'h13, 0, 0, 0));
    apply(mi(1, 1, 0, 'h08, 0, 1, 0, 'h40, 0, 'h14));
    @(negedge clk);
    check("rd_before_rst", mo(1, 0, 'h08, 0, 0, 1, 'h14, 0, 0, 0));
    #1 arst_n = 0;
    @(posedge clk);
    #1;
    step("post_rst", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'hEE), mo(1, 0, 'h30, 0, 0, 0, 0, 0, 0, 0));
    step("post1", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h15), mo(1, 0, 'h30, 0, 0, 1, 'h15, 0, 0, 0));
    step("post2", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h16), mo(1, 0, 'h30, 0, 0, 1, 'h16, 0, 0, 0));
    step("post3", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h17), mo(1, 0, 'h30, 0, 0, 1, 'h17, 0, 0, 0));
    step("post_force", mi(1, 1, 0, 'h30, 0, 1, 0, 'h40, 0, 'h18), mo(1, 0, 'h40, 0, 1, 1, 'h18, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
